// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between the two cache requesters, the arbiter and the shared tagged memory port.
// Latency: n/a (wires only).  Backpressure: n/a; acceptance is signalled by a non-zero response tag.
// Ports: icache request/response, dcache request/response, memory command/response/completion.
// Modport slave is the arbiter's view; modport master is the surrounding system (caches + memory).

interface mem_bus_arbiter_if #(
   parameter int ADDR_W = 64,
   parameter int TAG_W  = 4
);
   // icache side
   logic [1:0]        proc2Imem_command;
   logic [ADDR_W-1:0] proc2Imem_addr;
   logic [TAG_W-1:0]  Imem2proc_response;
   logic [ADDR_W-1:0] Imem2proc_data;
   logic [TAG_W-1:0]  Imem2proc_tag;
   // dcache side
   logic [1:0]        proc2Dmem_command;
   logic [ADDR_W-1:0] proc2Dmem_addr;
   logic [ADDR_W-1:0] proc2Dmem_data;
   logic [TAG_W-1:0]  Dmem2proc_response;
   logic [ADDR_W-1:0] Dmem2proc_data;
   logic [TAG_W-1:0]  Dmem2proc_tag;
   // memory side
   logic [1:0]        proc2mem_command;
   logic [ADDR_W-1:0] proc2mem_addr;
   logic [ADDR_W-1:0] proc2mem_data;
   logic [TAG_W-1:0]  mem2proc_response;
   logic [ADDR_W-1:0] mem2proc_data;
   logic [TAG_W-1:0]  mem2proc_tag;

   modport slave (
      input  proc2Imem_command, proc2Imem_addr,
      input  proc2Dmem_command, proc2Dmem_addr, proc2Dmem_data,
      input  mem2proc_response, mem2proc_data, mem2proc_tag,
      output Imem2proc_response, Imem2proc_data, Imem2proc_tag,
      output Dmem2proc_response, Dmem2proc_data, Dmem2proc_tag,
      output proc2mem_command, proc2mem_addr, proc2mem_data
   );

   modport master (
      output proc2Imem_command, proc2Imem_addr,
      output proc2Dmem_command, proc2Dmem_addr, proc2Dmem_data,
      output mem2proc_response, mem2proc_data, mem2proc_tag,
      input  Imem2proc_response, Imem2proc_data, Imem2proc_tag,
      input  Dmem2proc_response, Dmem2proc_data, Dmem2proc_tag,
      input  proc2mem_command, proc2mem_addr, proc2mem_data
   );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Shares one tagged memory port between icache and dcache; dcache has priority, with an icache anti-starvation override.
// Latency: grant/response routing is combinational (0 cycles); ownership table updates at the next clock edge.
// Backpressure: a loser (or a winner seeing response 0) gets response 0 and must hold its request and retry.
// Ports: clock, reset (async active-low); bus (slave modport: icache/dcache requests and responses, memory
//        command and completion); grant_dcache (debug, dcache owns the port this cycle); tag_err (sticky
//        flag: a completion tag arrived that no requester owns).

module mem_bus_arbiter #(
   parameter int NUM_MEM_TAGS = 15,
   parameter int STARVE_LIMIT = 4,
   parameter int ADDR_W       = 64
) (
   input  logic               clock,
   input  logic               reset,
   mem_bus_arbiter_if.slave   bus,
   output logic               grant_dcache,
   output logic               tag_err
);

   localparam int TAG_W = $clog2(NUM_MEM_TAGS + 1);
   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0]  STARVE_MAX = CNT_W'(STARVE_LIMIT);
   localparam logic [ADDR_W-1:0] ZERO_W     = '0;

   localparam logic [1:0] BUS_NONE  = 2'd0;
   localparam logic [1:0] BUS_LOAD  = 2'd1;
   localparam logic [1:0] BUS_STORE = 2'd2;

   // ownership table: owner 0 = icache, 1 = dcache; entry 0 is never valid
   logic [NUM_MEM_TAGS:0] valid_q, valid_d;
   logic [NUM_MEM_TAGS:0] owner_q, owner_d;
   logic [CNT_W-1:0]      starve_q, starve_d;
   logic                  tag_err_q, tag_err_d;

   logic             i_req, d_req;
   logic             grant_i, grant_d;
   logic             accept, load_acc;
   logic             cpl_hit, cpl_orphan;
   logic [TAG_W-1:0] acc_tag, cpl_tag;

   // icache can only load; an icache STORE is dropped as if idle
   assign i_req = (bus.proc2Imem_command == BUS_LOAD);
   assign d_req = (bus.proc2Dmem_command == BUS_LOAD) || (bus.proc2Dmem_command == BUS_STORE);

   // dcache wins contention unless icache has lost STARVE_LIMIT times in a row
   assign grant_d = d_req && !(i_req && (starve_q == STARVE_MAX));
   assign grant_i = i_req && !grant_d;

   assign acc_tag  = bus.mem2proc_response;
   assign accept   = (grant_i || grant_d) && (acc_tag != '0);
   assign load_acc = accept && (grant_i || (bus.proc2Dmem_command == BUS_LOAD));

   assign cpl_tag    = bus.mem2proc_tag;
   assign cpl_hit    = (cpl_tag != '0) && valid_q[cpl_tag];
   assign cpl_orphan = (cpl_tag != '0) && !valid_q[cpl_tag];

   // port routing
   always_comb begin
      bus.proc2mem_command   = BUS_NONE;
      bus.proc2mem_addr      = ZERO_W;
      bus.proc2mem_data      = ZERO_W;
      bus.Imem2proc_response = '0;
      bus.Dmem2proc_response = '0;
      if (grant_d) begin
         bus.proc2mem_command   = bus.proc2Dmem_command;
         bus.proc2mem_addr      = bus.proc2Dmem_addr;
         bus.proc2mem_data      = bus.proc2Dmem_data;
         bus.Dmem2proc_response = acc_tag;
      end else if (grant_i) begin
         bus.proc2mem_command   = BUS_LOAD;
         bus.proc2mem_addr      = bus.proc2Imem_addr;
         bus.Imem2proc_response = acc_tag;
      end
   end

   // completion steering: only a tag with a live owner is forwarded
   always_comb begin
      bus.Imem2proc_tag = '0;
      bus.Dmem2proc_tag = '0;
      if (cpl_hit) begin
         if (owner_q[cpl_tag]) bus.Dmem2proc_tag = cpl_tag;
         else                  bus.Imem2proc_tag = cpl_tag;
      end
   end

   assign bus.Imem2proc_data = bus.mem2proc_data;
   assign bus.Dmem2proc_data = bus.mem2proc_data;
   assign grant_dcache       = grant_d;
   assign tag_err            = tag_err_q;

   // next state
   always_comb begin
      valid_d   = valid_q;
      owner_d   = owner_q;
      tag_err_d = tag_err_q | cpl_orphan;
      starve_d  = '0;

      // clear before set, so a tag retired and re-issued in one cycle stays live under its new owner
      if (cpl_hit) valid_d[cpl_tag] = 1'b0;
      if (load_acc) begin
         valid_d[acc_tag] = 1'b1;
         owner_d[acc_tag] = grant_d;
      end

      if (i_req && !(grant_i && accept))
         starve_d = (starve_q == STARVE_MAX) ? STARVE_MAX : starve_q + 1'b1;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         valid_q   <= '0;
         owner_q   <= '0;
         starve_q  <= '0;
         tag_err_q <= 1'b0;
      end else begin
         valid_q   <= valid_d;
         owner_q   <= owner_d;
         starve_q  <= starve_d;
         tag_err_q <= tag_err_d;
      end
   end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: a table of single-cycle vectors with hand-computed results,
// followed by hand-written multi-cycle sequences (starvation override, zero response, mid-flight reset).
// Each vector is driven just after a rising edge and checked on the following falling edge.

module tb_mem_bus_arbiter;

   localparam logic [1:0] N = 2'd0;
   localparam logic [1:0] L = 2'd1;
   localparam logic [1:0] S = 2'd2;

   logic clock;
   logic reset;
   logic grant_dcache;
   logic tag_err;

   int nchk = 0;
   int nerr = 0;
   int ncyc = 0;

   mem_bus_arbiter_if #(.ADDR_W(64), .TAG_W(4)) bus ();

   mem_bus_arbiter #(.NUM_MEM_TAGS(15), .STARVE_LIMIT(4), .ADDR_W(64)) dut (
      .clock        (clock),
      .reset        (reset),
      .bus          (bus),
      .grant_dcache (grant_dcache),
      .tag_err      (tag_err)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic [1:0]  ic;
      logic [63:0] ia;
      logic [1:0]  dc;
      logic [63:0] da;
      logic [63:0] dd;
      logic [3:0]  rsp;
      logic [3:0]  mt;
      logic [3:0]  e_ir;
      logic [3:0]  e_dr;
      logic [3:0]  e_it;
      logic [3:0]  e_dt;
      logic [1:0]  e_pc;
      logic [63:0] e_pa;
      logic [63:0] e_pd;
      logic        e_gd;
      logic        e_te;
      string       nm;
   } vec_t;

   vec_t tbl [12];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic [1:0] ic, input logic [63:0] ia, input logic [1:0] dc,
                        input logic [63:0] da, input logic [63:0] dd, input logic [3:0] rsp,
                        input logic [3:0] mt, input logic [63:0] md);
      bus.proc2Imem_command = ic;
      bus.proc2Imem_addr    = ia;
      bus.proc2Dmem_command = dc;
      bus.proc2Dmem_addr    = da;
      bus.proc2Dmem_data    = dd;
      bus.mem2proc_response = rsp;
      bus.mem2proc_tag      = mt;
      bus.mem2proc_data     = md;
   endtask

   // one bus cycle: drive after the edge, check combinational outputs and tag_err mid-cycle
   task automatic cyc(input logic [1:0] ic, input logic [63:0] ia, input logic [1:0] dc,
                      input logic [63:0] da, input logic [63:0] dd, input logic [3:0] rsp,
                      input logic [3:0] mt,
                      input logic [3:0] e_ir, input logic [3:0] e_dr,
                      input logic [3:0] e_it, input logic [3:0] e_dt,
                      input logic [1:0] e_pc, input logic [63:0] e_pa, input logic [63:0] e_pd,
                      input logic e_gd, input logic e_te, input string nm);
      logic [63:0] md;
      @(posedge clock);
      #1;
      ncyc++;
      md = 64'hC0DE_0000_0000_0000 + 64'(ncyc);
      drive(ic, ia, dc, da, dd, rsp, mt, md);
      @(negedge clock);
      chk({nm, ".iresp"}, 64'(bus.Imem2proc_response), 64'(e_ir));
      chk({nm, ".dresp"}, 64'(bus.Dmem2proc_response), 64'(e_dr));
      chk({nm, ".itag"},  64'(bus.Imem2proc_tag),      64'(e_it));
      chk({nm, ".dtag"},  64'(bus.Dmem2proc_tag),      64'(e_dt));
      chk({nm, ".pcmd"},  64'(bus.proc2mem_command),   64'(e_pc));
      chk({nm, ".paddr"}, bus.proc2mem_addr,           e_pa);
      chk({nm, ".pdata"}, bus.proc2mem_data,           e_pd);
      chk({nm, ".grant"}, 64'(grant_dcache),           64'(e_gd));
      chk({nm, ".tagerr"}, 64'(tag_err),               64'(e_te));
      chk({nm, ".idata"}, bus.Imem2proc_data,          md);
      chk({nm, ".ddata"}, bus.Dmem2proc_data,          md);
   endtask

   initial begin
      //          ic ia        dc da        dd         rsp mt   ir dr it dt pc pa        pd         gd te  name
      tbl[0]  = '{L, 64'h100, N, 64'h0,   64'h0,     3,  0,   3, 0, 0, 0, L, 64'h100, 64'h0,     0, 0, "i_load"};
      tbl[1]  = '{N, 64'h0,   N, 64'h0,   64'h0,     0,  3,   0, 0, 3, 0, N, 64'h0,   64'h0,     0, 0, "i_cpl3"};
      tbl[2]  = '{N, 64'h0,   S, 64'h200, 64'hDEAD,  7,  0,   0, 7, 0, 0, S, 64'h200, 64'hDEAD,  1, 0, "d_store"};
      tbl[3]  = '{N, 64'h0,   N, 64'h0,   64'h0,     0,  7,   0, 0, 0, 0, N, 64'h0,   64'h0,     0, 0, "orphan7"};
      tbl[4]  = '{N, 64'h0,   N, 64'h0,   64'h0,     0,  0,   0, 0, 0, 0, N, 64'h0,   64'h0,     0, 1, "err_sticky"};
      tbl[5]  = '{L, 64'h140, N, 64'h0,   64'h0,     2,  0,   2, 0, 0, 0, L, 64'h140, 64'h0,     0, 1, "i_load2"};
      tbl[6]  = '{N, 64'h0,   L, 64'h300, 64'h55,    2,  2,   0, 2, 2, 0, L, 64'h300, 64'h55,    1, 1, "reaccept2"};
      tbl[7]  = '{N, 64'h0,   N, 64'h0,   64'h0,     0,  2,   0, 0, 0, 2, N, 64'h0,   64'h0,     0, 1, "d_cpl2"};
      tbl[8]  = '{N, 64'h0,   L, 64'h400, 64'h0,     0,  0,   0, 0, 0, 0, L, 64'h400, 64'h0,     1, 1, "d_noacc"};
      tbl[9]  = '{S, 64'h500, N, 64'h0,   64'h0,     9,  0,   0, 0, 0, 0, N, 64'h0,   64'h0,     0, 1, "i_store"};
      tbl[10] = '{S, 64'h500, L, 64'h700, 64'h0,     9,  0,   0, 9, 0, 0, L, 64'h700, 64'h0,     1, 1, "istore_dload"};
      tbl[11] = '{N, 64'h0,   N, 64'h0,   64'h0,     0,  9,   0, 0, 0, 9, N, 64'h0,   64'h0,     0, 1, "d_cpl9"};

      // reset state: a completion tag during reset must not be routed (empty table)
      reset = 1'b0;
      drive(N, 64'h0, N, 64'h0, 64'h0, 4'd0, 4'd3, 64'h0);
      repeat (2) @(posedge clock);
      @(negedge clock);
      chk("rst.tagerr", 64'(tag_err), 64'd0);
      chk("rst.grant",  64'(grant_dcache), 64'd0);
      chk("rst.itag",   64'(bus.Imem2proc_tag), 64'd0);
      chk("rst.dtag",   64'(bus.Dmem2proc_tag), 64'd0);
      chk("rst.pcmd",   64'(bus.proc2mem_command), 64'd0);
      chk("rst.paddr",  bus.proc2mem_addr, 64'd0);
      drive(N, 64'h0, N, 64'h0, 64'h0, 4'd0, 4'd0, 64'h0);
      reset = 1'b1;

      for (int i = 0; i < 12; i++)
         cyc(tbl[i].ic, tbl[i].ia, tbl[i].dc, tbl[i].da, tbl[i].dd, tbl[i].rsp, tbl[i].mt,
             tbl[i].e_ir, tbl[i].e_dr, tbl[i].e_it, tbl[i].e_dt, tbl[i].e_pc, tbl[i].e_pa,
             tbl[i].e_pd, tbl[i].e_gd, tbl[i].e_te, tbl[i].nm);

      // starvation: four dcache wins, then icache is forced through and the counter restarts
      cyc(L, 64'h1000, L, 64'h2000, 64'h77, 5,  0, 0, 5,  0, 0, L, 64'h2000, 64'h77, 1, 1, "stv1");
      cyc(L, 64'h1000, L, 64'h2000, 64'h77, 6,  0, 0, 6,  0, 0, L, 64'h2000, 64'h77, 1, 1, "stv2");
      cyc(L, 64'h1000, L, 64'h2000, 64'h77, 8,  0, 0, 8,  0, 0, L, 64'h2000, 64'h77, 1, 1, "stv3");
      cyc(L, 64'h1000, L, 64'h2000, 64'h77, 10, 0, 0, 10, 0, 0, L, 64'h2000, 64'h77, 1, 1, "stv4");
      cyc(L, 64'h1000, L, 64'h2000, 64'h77, 11, 0, 11, 0, 0, 0, L, 64'h1000, 64'h0,  0, 1, "stv5");
      cyc(L, 64'h1000, L, 64'h2000, 64'h77, 12, 0, 0, 12, 0, 0, L, 64'h2000, 64'h77, 1, 1, "stv6");
      cyc(N, 64'h0,    N, 64'h0,    64'h0,  0, 11, 0, 0, 11, 0, N, 64'h0,    64'h0,  0, 1, "stv_cpl11");

      // zero responses still count as icache losses; counter saturates until icache is accepted
      cyc(L, 64'h1000, L, 64'h2000, 64'h77, 0,  0, 0, 0,  0, 0, L, 64'h2000, 64'h77, 1, 1, "z1");
      cyc(L, 64'h1000, L, 64'h2000, 64'h77, 0,  0, 0, 0,  0, 0, L, 64'h2000, 64'h77, 1, 1, "z2");
      cyc(L, 64'h1000, L, 64'h2000, 64'h77, 0,  0, 0, 0,  0, 0, L, 64'h2000, 64'h77, 1, 1, "z3");
      cyc(L, 64'h1000, L, 64'h2000, 64'h77, 0,  0, 0, 0,  0, 0, L, 64'h2000, 64'h77, 1, 1, "z4");
      cyc(L, 64'h1000, L, 64'h2000, 64'h77, 0,  0, 0, 0,  0, 0, L, 64'h1000, 64'h0,  0, 1, "z5_forced");
      cyc(L, 64'h1000, L, 64'h2000, 64'h77, 13, 0, 13, 0, 0, 0, L, 64'h1000, 64'h0,  0, 1, "z6_sat");
      cyc(L, 64'h1000, L, 64'h2000, 64'h77, 14, 0, 0, 14, 0, 0, L, 64'h2000, 64'h77, 1, 1, "z7_clr");

      // reset with icache tag 4 outstanding: the late completion is dropped and flagged
      cyc(L, 64'h600, N, 64'h0, 64'h0, 4, 0, 4, 0, 0, 0, L, 64'h600, 64'h0, 0, 1, "pre_rst");
      @(posedge clock);
      #1;
      drive(N, 64'h0, N, 64'h0, 64'h0, 4'd0, 4'd0, 64'h0);
      reset = 1'b0;
      #1;
      chk("midrst.tagerr", 64'(tag_err), 64'd0);
      @(negedge clock);
      reset = 1'b1;
      cyc(N, 64'h0, N, 64'h0, 64'h0, 0, 4, 0, 0, 0, 0, N, 64'h0, 64'h0, 0, 0, "post_rst_cpl4");
      cyc(N, 64'h0, N, 64'h0, 64'h0, 0, 0, 0, 0, 0, 0, N, 64'h0, 64'h0, 0, 1, "post_rst_err");

      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

endmodule
